sram_arb: RTL and testbench



---
 rtl/sram_arb.sv | 190 +++++++++++++++++++
 tb/tb_sram_arb.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arb.sv
// Two-port round-robin arbiter for the single-port data SRAM.
// Tracks read ownership in a small FIFO so each response returns to its issuer.
// Optional feature macro: SRAM_ARB_LOCK_EN adds lock0_i/lock1_i grant locking.
module sram_arb #(
  parameter int unsigned Aw          = 11,
  parameter int unsigned Dw          = 32,
  parameter int unsigned Outstanding = 2,
  parameter int unsigned MaxLock     = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          req0_i,
  input  logic          we0_i,
  input  logic [Aw-1:0] addr0_i,
  input  logic [Dw-1:0] wdata0_i,
  input  logic [Dw-1:0] wmask0_i,
  output logic          gnt0_o,
  output logic [Dw-1:0] rdata0_o,
  output logic          rvalid0_o,
  input  logic          req1_i,
  input  logic          we1_i,
  input  logic [Aw-1:0] addr1_i,
  input  logic [Dw-1:0] wdata1_i,
  input  logic [Dw-1:0] wmask1_i,
  output logic          gnt1_o,
  output logic [Dw-1:0] rdata1_o,
  output logic          rvalid1_o,
`ifdef SRAM_ARB_LOCK_EN
  input  logic          lock0_i,
  input  logic          lock1_i,
`endif
  output logic          ram_req_o,
  output logic          ram_we_o,
  output logic [Aw-1:0] ram_addr_o,
  output logic [Dw-1:0] ram_wdata_o,
  output logic [Dw-1:0] ram_wmask_o,
  input  logic [Dw-1:0] ram_rdata_i,
  input  logic          ram_rvalid_i,
  output logic          err_o
);

  localparam int unsigned CntW = $clog2(Outstanding + 1);

  logic [1:0]             req;
  logic                   sel;       // port chosen this cycle (valid when a grant occurs)
  logic                   any_gnt;
  logic                   full;
  logic                   lock_hit;  // active lock owner is requesting
  logic                   prio_q, prio_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [Outstanding-1:0] own_q, own_d;  // owner IDs, entry 0 is the oldest read
  logic                   err_q, err_d;
  logic                   push, pop, stray;

  // Requests are ignored while reset is held.
  assign req  = {req1_i, req0_i} & {2{rst_ni}};
  assign full = (cnt_q == CntW'(Outstanding));

  // Pick the winner: lock owner first, then prio on contention, else the lone requester.
  always_comb begin : arbitrate
    sel = req[1];
    if (lock_hit) begin
      sel = lock_owner_sel();
    end else if (req == 2'b11) begin
      sel = prio_q;
    end
  end

  assign any_gnt = !full && (req != 2'b00);
  assign gnt0_o  = any_gnt & ~sel;
  assign gnt1_o  = any_gnt & sel;

  // RAM request mux; fields are zero when nothing is granted.
  always_comb begin : ram_mux
    ram_req_o   = any_gnt;
    ram_we_o    = 1'b0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    ram_wmask_o = '0;
    if (any_gnt) begin
      ram_we_o    = sel ? we1_i    : we0_i;
      ram_addr_o  = sel ? addr1_i  : addr0_i;
      ram_wdata_o = sel ? wdata1_i : wdata0_i;
      ram_wmask_o = sel ? wmask1_i : wmask0_i;
    end
  end

  assign push  = any_gnt & ~ram_we_o;
  assign pop   = rst_ni & ram_rvalid_i & (cnt_q != '0);
  assign stray = ram_rvalid_i & (cnt_q == '0);

  assign rvalid0_o = pop & ~own_q[0];
  assign rvalid1_o = pop & own_q[0];
  assign rdata0_o  = ram_rdata_i;
  assign rdata1_o  = ram_rdata_i;
  assign err_o     = err_q;

  // Owner FIFO as a shift register: pop shifts toward the head, push lands at the tail.
  always_comb begin : fifo_next
    own_d = own_q;
    cnt_d = cnt_q;
    if (pop) begin
      own_d = own_q >> 1;
      cnt_d = cnt_d - CntW'(1);
    end
    if (push) begin
      for (int unsigned i = 0; i < Outstanding; i++) begin
        if (CntW'(i) == cnt_d) own_d[i] = sel;
      end
      cnt_d = cnt_d + CntW'(1);
    end
  end

  // Round-robin pointer and sticky error; a MaxLock release also lands prio on the other port.
  always_comb begin : misc_next
    prio_d = any_gnt ? ~sel : prio_q;
    err_d  = err_q | stray;
  end

  // Arbiter state register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      prio_q <= 1'b0;
      cnt_q  <= '0;
      own_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      prio_q <= prio_d;
      cnt_q  <= cnt_d;
      own_q  <= own_d;
      err_q  <= err_d;
    end
  end

`ifdef SRAM_ARB_LOCK_EN
  localparam int unsigned BeatW = $clog2(MaxLock + 1);

  logic [1:0]       lock_in;
  logic             lock_act_q, lock_act_d;
  logic             lock_owner_q, lock_owner_d;
  logic [BeatW-1:0] beat_q, beat_d;

  assign lock_in  = {lock1_i, lock0_i};
  assign lock_hit = lock_act_q & req[lock_owner_q];

  function automatic logic lock_owner_sel();
    return lock_owner_q;
  endfunction

  // Lock tracking: start/continue on a locked grant, drop on unlock, owner idle or beat limit.
  always_comb begin : lock_next
    lock_act_d   = lock_act_q;
    lock_owner_d = lock_owner_q;
    beat_d       = beat_q;
    if (lock_act_q && !req[lock_owner_q]) lock_act_d = 1'b0;
    if (any_gnt) begin
      if (lock_in[sel]) begin
        beat_d       = lock_hit ? beat_q + BeatW'(1) : BeatW'(1);
        lock_owner_d = sel;
        lock_act_d   = (beat_d != BeatW'(MaxLock));
      end else begin
        lock_act_d = 1'b0;
      end
    end
  end

  // Lock state register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      lock_act_q   <= 1'b0;
      lock_owner_q <= 1'b0;
      beat_q       <= '0;
    end else begin
      lock_act_q   <= lock_act_d;
      lock_owner_q <= lock_owner_d;
      beat_q       <= beat_d;
    end
  end
`else
  logic unused_max_lock;

  assign lock_hit        = 1'b0;
  assign unused_max_lock = ^32'(MaxLock);

  function automatic logic lock_owner_sel();
    return 1'b0;
  endfunction
`endif

endmodule

// File: tb/tb_sram_arb.sv
// Randomized bench for sram_arb with a queue-based reference model and a small RAM model.
module tb_sram_arb;

  localparam int unsigned Out = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, we0, req1, we1;
  logic [10:0] addr0, addr1;
  logic [31:0] wdata0, wmask0, wdata1, wmask1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [31:0] rdata0, rdata1;
  logic        ram_req, ram_we;
  logic [10:0] ram_addr;
  logic [31:0] ram_wdata, ram_wmask, ram_rdata;
  logic        ram_rvalid, err;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit          m_prio;
  bit          m_own[$];
  bit          m_err;
  logic        last_g0, last_g1;
  // RAM model state
  logic [31:0] mem [64];
  logic [31:0] pend[$];
  bit          resp_real;
  int          rv_mode;  // 0 stall, 1 respond every cycle, 2 random

  sram_arb dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req0_i      (req0),
    .we0_i       (we0),
    .addr0_i     (addr0),
    .wdata0_i    (wdata0),
    .wmask0_i    (wmask0),
    .gnt0_o      (gnt0),
    .rdata0_o    (rdata0),
    .rvalid0_o   (rvalid0),
    .req1_i      (req1),
    .we1_i       (we1),
    .addr1_i     (addr1),
    .wdata1_i    (wdata1),
    .wmask1_i    (wmask1),
    .gnt1_o      (gnt1),
    .rdata1_o    (rdata1),
    .rvalid1_o   (rvalid1),
`ifdef SRAM_ARB_LOCK_EN
    .lock0_i     (1'b0),
    .lock1_i     (1'b0),
`endif
    .ram_req_o   (ram_req),
    .ram_we_o    (ram_we),
    .ram_addr_o  (ram_addr),
    .ram_wdata_o (ram_wdata),
    .ram_wmask_o (ram_wmask),
    .ram_rdata_i (ram_rdata),
    .ram_rvalid_i(ram_rvalid),
    .err_o       (err)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Model and compare, once per cycle at the falling edge.
  logic        e_g0, e_g1, e_rv0, e_rv1, e_we;
  logic [10:0] e_addr;
  logic [31:0] e_wd, e_wm;
  always @(negedge clk) begin
    e_g0 = 0; e_g1 = 0; e_rv0 = 0; e_rv1 = 0; e_we = 0;
    e_addr = '0; e_wd = '0; e_wm = '0;
    if (rst_n) begin
      if (m_own.size() < Out) begin
        if (req0 && req1) begin
          e_g0 = (m_prio == 1'b0);
          e_g1 = (m_prio == 1'b1);
        end else begin
          e_g0 = req0;
          e_g1 = req1;
        end
      end
      if (e_g0) begin
        e_we = we0; e_addr = addr0; e_wd = wdata0; e_wm = wmask0;
      end else if (e_g1) begin
        e_we = we1; e_addr = addr1; e_wd = wdata1; e_wm = wmask1;
      end
      if (ram_rvalid && m_own.size() > 0) begin
        e_rv0 = (m_own[0] == 1'b0);
        e_rv1 = (m_own[0] == 1'b1);
      end
    end
    chk("gnt0", 64'(gnt0), 64'(e_g0));
    chk("gnt1", 64'(gnt1), 64'(e_g1));
    chk("rvalid0", 64'(rvalid0), 64'(e_rv0));
    chk("rvalid1", 64'(rvalid1), 64'(e_rv1));
    chk("ram_req", 64'(ram_req), 64'(e_g0 | e_g1));
    chk("ram_we", 64'(ram_we), 64'(e_we));
    chk("ram_addr", 64'(ram_addr), 64'(e_addr));
    chk("ram_wdata", 64'(ram_wdata), 64'(e_wd));
    chk("ram_wmask", 64'(ram_wmask), 64'(e_wm));
    chk("rdata0", 64'(rdata0), 64'(ram_rdata));
    chk("rdata1", 64'(rdata1), 64'(ram_rdata));
    chk("err", 64'(err), 64'(m_err));
    if (!rst_n) begin
      m_prio = 0;
      m_own.delete();
      m_err = 0;
    end else begin
      if (ram_rvalid) begin
        if (m_own.size() > 0) void'(m_own.pop_front());
        else m_err = 1;
      end
      if ((e_g0 || e_g1) && !e_we) m_own.push_back(e_g1);
      if (e_g0) m_prio = 1;
      else if (e_g1) m_prio = 0;
    end
    last_g0 = e_g0;
    last_g1 = e_g1;
    // RAM macro behaviour
    if (ram_rvalid && resp_real && pend.size() > 0) void'(pend.pop_front());
    if (ram_req) begin
      if (ram_we) mem[ram_addr[5:0]] = (mem[ram_addr[5:0]] & ~ram_wmask) | (ram_wdata & ram_wmask);
      else pend.push_back(mem[ram_addr[5:0]]);
    end
  end

  task automatic drive_ram();
    resp_real  = 0;
    ram_rvalid = 0;
    ram_rdata  = $urandom;
    if (pend.size() > 0 && (rv_mode == 1 || (rv_mode == 2 && $urandom_range(0, 2) != 0))) begin
      ram_rvalid = 1;
      ram_rdata  = pend[0];
      resp_real  = 1;
    end else if (pend.size() == 0 && rv_mode == 2 && $urandom_range(0, 149) == 0) begin
      ram_rvalid = 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drive_ram();
  endtask

  task automatic idle(input int n);
    req0 = 0; req1 = 0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    logic [3:0] x_g0, x_rv0, x_rv1;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    rst_n = 0; req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0; wmask0 = '0;
    req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0; wmask1 = '0;
    ram_rvalid = 0; ram_rdata = '0; rv_mode = 1;
    last_g0 = 0; last_g1 = 0;
    tick(); tick();
    @(negedge clk);
    chk("reset_gnt", 64'({gnt1, gnt0, ram_req}), 64'd0);
    chk("reset_err", 64'(err), 64'd0);

    // Both ports read at once: grants alternate, responses go back in order.
    x_g0 = 4'b0101; x_rv0 = 4'b1010; x_rv1 = 4'b0100;
    for (int c = 0; c < 4; c++) begin
      tick();
      rst_n = 1;
      req0 = 1; we0 = 0; addr0 = 11'h10;
      req1 = 1; we1 = 0; addr1 = 11'h20;
      @(negedge clk);
      chk("alt_gnt0", 64'(gnt0), 64'(x_g0[c]));
      chk("alt_addr", 64'(ram_addr), (c % 2 == 0) ? 64'h10 : 64'h20);
      chk("alt_rv0", 64'(rvalid0), 64'(x_rv0[c]));
      chk("alt_rv1", 64'(rvalid1), 64'(x_rv1[c]));
    end
    tick(); req0 = 0; req1 = 0;
    @(negedge clk);
    chk("alt_last_rv1", 64'(rvalid1), 64'd1);
    idle(3);

    // Backpressure with the RAM stalled: third read waits for one response.
    rv_mode = 0;
    for (int c = 0; c < 5; c++) begin
      rv_mode = (c == 3) ? 1 : 0;
      tick();
      req0 = 1; we0 = 0; addr0 = (c < 2) ? 11'(c + 1) : 11'd3;
      @(negedge clk);
      chk("bp_gnt0", 64'(gnt0), (c == 2 || c == 3) ? 64'd0 : 64'd1);
    end
    rv_mode = 1;
    idle(4);

    // Masked write and read to the same address, port 0 first.
    rst_n = 0; tick(); tick();
    rst_n = 1;
    req0 = 1; we0 = 1; addr0 = 11'd5; wdata0 = 32'hDEADBEEF; wmask0 = 32'h0000FFFF;
    req1 = 1; we1 = 0; addr1 = 11'd5;
    @(negedge clk);
    chk("mix_gnt0", 64'({gnt1, gnt0}), 64'b01);
    chk("mix_wdata", 64'(ram_wdata), 64'hDEADBEEF);
    chk("mix_wmask", 64'(ram_wmask), 64'h0000FFFF);
    tick(); req0 = 0;
    @(negedge clk);
    chk("mix_gnt1", 64'({gnt1, gnt0, ram_we}), 64'b100);
    tick(); req1 = 0;
    @(negedge clk);
    chk("mix_rv", 64'({rvalid1, rvalid0}), 64'b10);
    chk("mix_rdata1", 64'(rdata1), 64'h0000BEEF);
    idle(2);

    // Reset with reads in flight: the late responses are strays.
    rv_mode = 0;
    tick(); req0 = 1; we0 = 0; addr0 = 11'd7;
    tick(); addr0 = 11'd8;
    tick(); req0 = 0; rst_n = 0;
    @(negedge clk);
    chk("rst_quiet", 64'({gnt0, gnt1, ram_req, rvalid0, rvalid1}), 64'd0);
    rv_mode = 1;
    tick(); rst_n = 1;
    @(negedge clk);
    chk("stray_rv", 64'({rvalid1, rvalid0}), 64'd0);
    tick();
    rv_mode = 0;
    @(negedge clk);
    chk("stray_err", 64'(err), 64'd1);
    tick(); tick();
    @(negedge clk);
    chk("err_sticky", 64'(err), 64'd1);
    rst_n = 0; tick(); tick(); rst_n = 1;
    @(negedge clk);
    chk("err_cleared", 64'(err), 64'd0);

    // Random traffic; requesters hold their fields until granted.
    rv_mode = 2;
    req0 = 0; req1 = 0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      rst_n = ($urandom_range(0, 299) != 0);
      if (!(req0 && !last_g0)) begin
        req0 = ($urandom_range(0, 99) < 60); we0 = ($urandom_range(0, 2) == 0);
        addr0 = 11'($urandom_range(0, 63)); wdata0 = $urandom; wmask0 = $urandom;
      end
      if (!(req1 && !last_g1)) begin
        req1 = ($urandom_range(0, 99) < 60); we1 = ($urandom_range(0, 2) == 0);
        addr1 = 11'($urandom_range(0, 63)); wdata1 = $urandom; wmask1 = $urandom;
      end
    end
    rst_n = 1;
    idle(10);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
